execution_md: RTL and testbench
===============================

Name: execution_md

Overview:
- Parametrised next-generation execute stage: base-ALU datapath with EX/MEM and MEM/WB forwarding, plus an iterative RV32M multiply/divide unit.
- Sits between the ID/EX and EX/MEM pipeline registers.
- Base ops resolve in the same cycle.
- M-extension ops run a multi-cycle sequence and hold the pipeline through a stall handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width; the divider iterates this many cycles.
- PC_WIDTH, 32, program counter width.
- RADDR_WIDTH, 5, register address width.
- ALUOP_WIDTH, 5, alu_op width; widened from 4 to hold the M ops.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  ID/EX holds a valid instruction.
- flush  in  1  kill the in-flight instruction (branch or exception).
- pc  in  PC_WIDTH  instruction PC.
- branch_jump  in  1  JAL/JALR select for ALU_ADDPC.
- alu_src  in  1  1 = imm, 0 = forwarded rs2.
- alu_op  in  ALUOP_WIDTH  operation code.
- imm, reg_rdata1, reg_rdata2  in  DATA_WIDTH  immediate and register-file read data.
- rs1, rs2  in  RADDR_WIDTH  source register addresses.
- exmem_reg_write, memwb_reg_write  in  1  forwarding-source write enables.
- exmem_reg_rd, memwb_reg_rd  in  RADDR_WIDTH  forwarding-source destination registers.
- exmem_reg_wdata, wb_reg_wdata  in  DATA_WIDTH  forwarding data.
- alu_result  out  DATA_WIDTH  result to EX/MEM.
- mem_wdata  out  DATA_WIDTH  forwarded rs2 for stores.
- ex_stall  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- md_busy  out  1  mul/div FSM not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Forwarding priority, per source: EX/MEM if write enabled, rd != x0 and rd == rs; else MEM/WB under the same rule; else register-file data.
- mem_wdata = forwarded rs2, always.
- Base ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, LT, LTU, ADDPC):
  - combinational, zero latency, ex_stall = 0;
  - shift amount = operand2[log2(DATA_WIDTH)-1:0];
  - SRA is a true arithmetic shift (signed cast);
  - ADDPC gives pc+4 when branch_jump = 1, else pc+operand2;
  - unknown op gives 0.
- M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, always register-register.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Leave when ex_valid & M op & !flush.
  - Latch forwarded operands, op, and a sign-fix flag. Operands are captured this cycle only, because the forwarding sources move while stalled.
  - Signed ops latch magnitudes.
  - Special divides go directly to DONE with a preset result. Divisor 0: quotient all-ones, remainder = dividend. Signed most-negative / -1: quotient = dividend, remainder 0.
  - Otherwise go to CALC with the counter cleared.
- CALC, one bit per cycle for DATA_WIDTH cycles:
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring, quotient/remainder registers.
  - When the counter reaches DATA_WIDTH-1, go to DONE.
- DONE:
  - Apply the sign fix (two's complement of product, quotient or remainder as required).
  - Select the low or high product half, or quotient or remainder.
  - alu_result = registered result, ex_stall = 0, return to IDLE.
- ex_stall = ex_valid & M op & (state != DONE).
- Latency: normal M op stalls DATA_WIDTH+1 cycles and the result appears in cycle DATA_WIDTH+2 from issue. A special divide stalls 1 cycle and completes in the 2nd cycle.
- Flush in any state: go to IDLE next cycle, ex_stall = 0 in the flush cycle, no result.
- rst_n = 0: state IDLE, counter 0, result and accumulator registers 0, ex_stall = 0, md_busy = 0.
- Reset mid-CALC aborts with no output.
- While in CALC/DONE, changes on reg_rdata, rs or forwarding inputs have no effect on the result.
- ex_valid = 0 while in IDLE: no state change.
- md_busy = (state != IDLE).

Decomposition:
- Add to define.vh:
  - the ALU_MUL..ALU_REMU codes, 5-bit, distinct from existing codes;
  - the MD state encodings;
  - the MD op-class decode macros (is_md, is_signed_a/b, is_high, is_rem).
- One sub-module, md_iter_unit: the FSM, counter, accumulator and sign fix. It has start/flush inputs and done/result outputs.
- Forwarding and base ALU stay in execution_md.

Test Plan:
- Forwarding: EX/MEM and MEM/WB both match rs1 = x5, wdata 0x11 and 0x22, op ADD, operand2 = 1 -> alu_result 0x12. Same case with exmem_reg_rd = x0 -> alu_result 0x23.
- MUL 0x0000_0007 × 0xFFFF_FFFD (−3) -> ex_stall high 33 cycles; alu_result 0xFFFF_FFEB. MULH on the same operands -> 0xFFFF_FFFF. MULHU -> 0x0000_0006.
- DIV −20 / 3 -> quotient 0xFFFF_FFFA (−6). REM on the same operands -> 0xFFFF_FFFE (−2).
- DIVU x / 0 with x = 0x1234 -> 2-cycle completion, quotient 0xFFFF_FFFF. REMU -> 0x1234. DIV 0x8000_0000 / −1 -> 0x8000_0000.
- Forwarding source changes mid-CALC: after capture, exmem_reg_wdata flips -> result unchanged.
- Flush at CALC cycle 10 -> md_busy 0 next cycle, ex_stall 0 in the flush cycle. A following ADD completes normally.
- rst_n low at CALC cycle 5 -> state IDLE, all outputs 0 on the next edge.

Source files
------------

// File: rtl/execution_md_pkg.sv
// Shared ALU op codes, mul/div FSM states and M-extension op-class decode helpers
// for the execute stage.
package execution_md_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_LT     = 5'd8;
    localparam logic [4:0] ALU_LTU    = 5'd9;
    localparam logic [4:0] ALU_ADDPC  = 5'd10;

    // M ops occupy 5'b10xxx so the op class falls out of individual bits.
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_md(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic md_is_div(input logic [4:0] op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input logic [4:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic md_is_high(input logic [4:0] op);
        return !op[2] && (op[1:0] != 2'b00);
    endfunction

    function automatic logic md_signed_a(input logic [4:0] op);
        return op[2] ? !op[0] : (op[1:0] != 2'b11);
    endfunction

    function automatic logic md_signed_b(input logic [4:0] op);
        return op[2] ? !op[0] : !op[1];
    endfunction

endpackage

// File: rtl/execution_md_md_iter_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared
// 2*DATA_WIDTH accumulator, with sign fix-up and result select in DONE.
module md_iter_unit
    import execution_md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [4:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned AW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    md_state_e state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [4:0]            op_q, op_d;
    logic                  neg_q, neg_d;

    logic                  a_neg, b_neg, div_zero, div_ovf, special;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic [DATA_WIDTH:0]   mul_sum, div_rem, div_rem_sub;
    logic                  div_ge;
    logic [AW-1:0]         mul_next, div_next, prod_fix;
    logic [DATA_WIDTH-1:0] div_sel, div_fix;

    always_comb begin
        a_neg    = md_signed_a(op_i) & a_i[DATA_WIDTH-1];
        b_neg    = md_signed_b(op_i) & b_i[DATA_WIDTH-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = (b_i == '0);
        div_ovf  = md_signed_a(op_i) && (a_i == MOST_NEG) && (b_i == '1);
        special  = md_is_div(op_i) & (div_zero | div_ovf);
    end

    // Multiply: multiplier sits in the low half and is consumed LSB first while
    // partial sums shift down from the high half.
    // Divide: {remainder, quotient} shift left together, restoring subtract.
    always_comb begin
        mul_sum     = {1'b0, acc_q[AW-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next    = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        div_rem     = {acc_q[AW-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]};
        div_ge      = (div_rem >= {1'b0, opb_q});
        div_rem_sub = div_ge ? (div_rem - {1'b0, opb_q}) : div_rem;
        div_next    = {div_rem_sub[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start_i) state_d = special ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt_q == CNT_LAST) state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush_i) state_d = MD_IDLE;
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        opb_d = opb_q;
        op_d  = op_q;
        neg_d = neg_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d  = op_i;
                    cnt_d = '0;
                    if (special) begin
                        opb_d = b_i;
                        neg_d = 1'b0;
                        acc_d = div_zero ? {a_i, {DATA_WIDTH{1'b1}}}
                                         : {{DATA_WIDTH{1'b0}}, a_i};
                    end else begin
                        opb_d = b_mag;
                        acc_d = {{DATA_WIDTH{1'b0}}, a_mag};
                        neg_d = md_is_rem(op_i) ? a_neg : (a_neg ^ b_neg);
                    end
                end
            end
            MD_CALC: begin
                acc_d = md_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
            op_q  <= op_d;
            neg_q <= neg_d;
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        div_sel  = md_is_rem(op_q) ? acc_q[AW-1:DATA_WIDTH] : acc_q[DATA_WIDTH-1:0];
        div_fix  = neg_q ? -div_sel : div_sel;
        done_o   = (state_q == MD_DONE);
        busy_o   = (state_q != MD_IDLE);
        result_o = '0;
        if (state_q == MD_DONE) begin
            if (md_is_div(op_q)) begin
                result_o = div_fix;
            end else if (md_is_high(op_q)) begin
                result_o = prod_fix[AW-1:DATA_WIDTH];
            end else begin
                result_o = prod_fix[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/execution_md.sv
// Execute stage: operand forwarding, single-cycle base ALU and a stalling
// iterative multiply/divide unit for the M extension.
module execution_md
    import execution_md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned RADDR_WIDTH = 5,
    parameter int unsigned ALUOP_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   branch_jump,
    input  logic                   alu_src,
    input  logic [ALUOP_WIDTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]  imm,
    input  logic [DATA_WIDTH-1:0]  reg_rdata1,
    input  logic [DATA_WIDTH-1:0]  reg_rdata2,
    input  logic [RADDR_WIDTH-1:0] rs1,
    input  logic [RADDR_WIDTH-1:0] rs2,
    input  logic                   exmem_reg_write,
    input  logic                   memwb_reg_write,
    input  logic [RADDR_WIDTH-1:0] exmem_reg_rd,
    input  logic [RADDR_WIDTH-1:0] memwb_reg_rd,
    input  logic [DATA_WIDTH-1:0]  exmem_reg_wdata,
    input  logic [DATA_WIDTH-1:0]  wb_reg_wdata,
    output logic [DATA_WIDTH-1:0]  alu_result,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   ex_stall,
    output logic                   md_busy
);

    localparam int unsigned SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] op1, rs2_fwd, op2, base_result, md_result;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [SHW-1:0]        shamt;
    logic [4:0]            op5;
    logic                  op_hi_zero, md_op, md_start, md_done;

    always_comb begin
        if (exmem_reg_write && (exmem_reg_rd != '0) && (exmem_reg_rd == rs1)) begin
            op1 = exmem_reg_wdata;
        end else if (memwb_reg_write && (memwb_reg_rd != '0) && (memwb_reg_rd == rs1)) begin
            op1 = wb_reg_wdata;
        end else begin
            op1 = reg_rdata1;
        end

        if (exmem_reg_write && (exmem_reg_rd != '0) && (exmem_reg_rd == rs2)) begin
            rs2_fwd = exmem_reg_wdata;
        end else if (memwb_reg_write && (memwb_reg_rd != '0) && (memwb_reg_rd == rs2)) begin
            rs2_fwd = wb_reg_wdata;
        end else begin
            rs2_fwd = reg_rdata2;
        end
    end

    assign op2       = alu_src ? imm : rs2_fwd;
    assign mem_wdata = rs2_fwd;
    assign shamt     = op2[SHW-1:0];
    assign pc_next   = branch_jump ? (pc + PC_WIDTH'(4)) : (pc + PC_WIDTH'(op2));

    // Codes above the 5-bit space decode as unknown ops.
    assign op5        = alu_op[4:0];
    assign op_hi_zero = ((alu_op >> 5) == '0);
    assign md_op      = op_hi_zero & md_is_md(op5);

    always_comb begin
        base_result = '0;
        if (op_hi_zero) begin
            case (op5)
                ALU_ADD:   base_result = op1 + op2;
                ALU_SUB:   base_result = op1 - op2;
                ALU_AND:   base_result = op1 & op2;
                ALU_OR:    base_result = op1 | op2;
                ALU_XOR:   base_result = op1 ^ op2;
                ALU_SLL:   base_result = op1 << shamt;
                ALU_SRL:   base_result = op1 >> shamt;
                ALU_SRA:   base_result = DATA_WIDTH'($signed(op1) >>> shamt);
                ALU_LT:    base_result = DATA_WIDTH'($signed(op1) < $signed(op2));
                ALU_LTU:   base_result = DATA_WIDTH'(op1 < op2);
                ALU_ADDPC: base_result = DATA_WIDTH'(pc_next);
                default:   base_result = '0;
            endcase
        end
    end

    assign md_start = ex_valid & md_op & ~flush;

    md_iter_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_md (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (md_start),
        .flush_i  (flush),
        .op_i     (op5),
        .a_i      (op1),
        .b_i      (rs2_fwd),
        .done_o   (md_done),
        .busy_o   (md_busy),
        .result_o (md_result)
    );

    assign alu_result = (md_done & ~flush) ? md_result : base_result;
    assign ex_stall   = rst_n & ex_valid & md_op & ~md_done & ~flush;

endmodule

// File: tb/tb_execution_md.sv
// Directed bench for execution_md: a cycle-level reference model checks every
// output each cycle, and hand-computed literals pin the model.
module tb_execution_md;
    import execution_md_pkg::*;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst_n, ex_valid, flush, branch_jump, alu_src;
    logic [31:0] pc, imm, reg_rdata1, reg_rdata2, exmem_reg_wdata, wb_reg_wdata;
    logic [4:0]  alu_op, rs1, rs2, exmem_reg_rd, memwb_reg_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] alu_result, mem_wdata;
    logic        ex_stall, md_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    execution_md #(
        .DATA_WIDTH  (32),
        .PC_WIDTH    (32),
        .RADDR_WIDTH (5),
        .ALUOP_WIDTH (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .flush           (flush),
        .pc              (pc),
        .branch_jump     (branch_jump),
        .alu_src         (alu_src),
        .alu_op          (alu_op),
        .imm             (imm),
        .reg_rdata1      (reg_rdata1),
        .reg_rdata2      (reg_rdata2),
        .rs1             (rs1),
        .rs2             (rs2),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_reg_rd    (exmem_reg_rd),
        .memwb_reg_rd    (memwb_reg_rd),
        .exmem_reg_wdata (exmem_reg_wdata),
        .wb_reg_wdata    (wb_reg_wdata),
        .alu_result      (alu_result),
        .mem_wdata       (mem_wdata),
        .ex_stall        (ex_stall),
        .md_busy         (md_busy)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] rf);
        if (exmem_reg_write && exmem_reg_rd != 5'd0 && exmem_reg_rd == rs) return exmem_reg_wdata;
        if (memwb_reg_write && memwb_reg_rd != 5'd0 && memwb_reg_rd == rs) return wb_reg_wdata;
        return rf;
    endfunction

    function automatic bit is_m(logic [4:0] op);
        return op >= ALU_MUL && op <= ALU_REMU;
    endfunction

    function automatic logic [31:0] base_ref(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [31:0] p, logic bj);
        int sh = int'(b[4:0]);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << sh;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return $unsigned($signed(a) >>> sh);
            ALU_LT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_LTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_ADDPC: return bj ? p + 32'd4 : p + b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic bit div_ovf(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        return (op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] md_ref(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'd0, a};
        longint ub = {32'd0, b};
        longint p;
        case (op)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : div_ovf(op, a, b) ? a
                               : $unsigned($signed(a) / $signed(b));
            ALU_REM:    return (b == 0) ? a : div_ovf(op, a, b) ? 32'd0
                               : $unsigned($signed(a) % $signed(b));
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int md_lat(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        if (op >= ALU_DIV && (b == 0 || div_ovf(op, a, b))) return 1;
        return DW + 1;
    endfunction

    // k = cycles since an M op was accepted, -1 when the model is idle.
    int          k = -1;
    int          lat = 0;
    logic [31:0] mexp = '0;
    bit          rst_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_stall", {31'd0, ex_stall}, 32'd0);
            if (rst_prev) begin
                chk("rst_busy", {31'd0, md_busy}, 32'd0);
                if (is_m(alu_op)) chk("rst_result", alu_result, 32'd0);
            end
            rst_prev = 1'b1;
            k = -1;
        end else begin
            rst_prev = 1'b0;
            chk("mem_wdata", mem_wdata, fwd(rs2, reg_rdata2));
            if (k >= 0) begin
                chk("md_busy", {31'd0, md_busy}, (k > 0) ? 32'd1 : 32'd0);
                if (flush) begin
                    chk("flush_stall", {31'd0, ex_stall}, 32'd0);
                    k = -1;
                end else if (k < lat) begin
                    chk("md_stall", {31'd0, ex_stall}, {31'd0, ex_valid});
                    k++;
                end else begin
                    chk("md_done_stall", {31'd0, ex_stall}, 32'd0);
                    chk("md_result", alu_result, mexp);
                    k = -1;
                end
            end else begin
                chk("idle_busy", {31'd0, md_busy}, 32'd0);
                if (ex_valid && is_m(alu_op) && !flush) begin
                    mexp = md_ref(alu_op, fwd(rs1, reg_rdata1), fwd(rs2, reg_rdata2));
                    lat  = md_lat(alu_op, fwd(rs1, reg_rdata1), fwd(rs2, reg_rdata2));
                    chk("issue_stall", {31'd0, ex_stall}, 32'd1);
                    k = 1;
                end else begin
                    chk("idle_stall", {31'd0, ex_stall}, 32'd0);
                    if (ex_valid && !is_m(alu_op))
                        chk("base_result", alu_result,
                            base_ref(alu_op, fwd(rs1, reg_rdata1),
                                     alu_src ? imm : fwd(rs2, reg_rdata2), pc, branch_jump));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        rs1 = 5'd1; rs2 = 5'd2;
        reg_rdata1 = a; reg_rdata2 = b;
        alu_src = 1'b0; alu_op = op; imm = 32'd0;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        exmem_reg_rd = 5'd0; memwb_reg_rd = 5'd0;
        flush = 1'b0; ex_valid = 1'b1;
    endtask

    task automatic base(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] p, logic bj, logic [31:0] exp);
        set_rr(op, a, b);
        pc = p; branch_jump = bj;
        @(negedge clk);
        chk(name, alu_result, exp);
        step();
        ex_valid = 1'b0;
    endtask

    // flip_at >= 0: rs1 comes from EX/MEM and that source changes during CALC.
    task automatic run_md(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp, int exp_stalls, int flip_at);
        int stalls = 0;
        bit done = 1'b0;
        set_rr(op, a, b);
        if (flip_at >= 0) begin
            rs1 = 5'd5; reg_rdata1 = 32'd0;
            exmem_reg_write = 1'b1; exmem_reg_rd = 5'd5; exmem_reg_wdata = a;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            if (i == flip_at) begin
                @(posedge clk); #1;
                exmem_reg_wdata = ~exmem_reg_wdata;
            end
            @(negedge clk);
            if (ex_stall) stalls++;
            else done = 1'b1;
        end
        chk({name, "_result"}, alu_result, exp);
        chk({name, "_stalls"}, stalls, exp_stalls);
        step();
        ex_valid = 1'b0;
        exmem_reg_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; branch_jump = 1'b0; alu_src = 1'b0;
        pc = '0; imm = '0; reg_rdata1 = '0; reg_rdata2 = '0;
        exmem_reg_wdata = '0; wb_reg_wdata = '0; alu_op = ALU_ADD;
        rs1 = '0; rs2 = '0; exmem_reg_rd = '0; memwb_reg_rd = '0;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_stall", {31'd0, ex_stall}, 32'd0);
        step();

        // Forwarding priority
        set_rr(ALU_ADD, 32'h0, 32'h0);
        rs1 = 5'd5; alu_src = 1'b1; imm = 32'd1;
        exmem_reg_write = 1'b1; exmem_reg_rd = 5'd5; exmem_reg_wdata = 32'h11;
        memwb_reg_write = 1'b1; memwb_reg_rd = 5'd5; wb_reg_wdata = 32'h22;
        @(negedge clk);
        chk("fwd_exmem", alu_result, 32'h12);
        step();
        exmem_reg_rd = 5'd0;
        @(negedge clk);
        chk("fwd_memwb", alu_result, 32'h23);
        step();
        ex_valid = 1'b0;

        // Base ops
        base("sub",      ALU_SUB,   32'd5,          32'd7,   32'd0,     1'b0, 32'hFFFF_FFFE);
        base("sll_mask", ALU_SLL,   32'd1,          32'h3F,  32'd0,     1'b0, 32'h8000_0000);
        base("srl",      ALU_SRL,   32'h8000_0000,  32'd4,   32'd0,     1'b0, 32'h0800_0000);
        base("sra",      ALU_SRA,   32'h8000_0000,  32'd4,   32'd0,     1'b0, 32'hF800_0000);
        base("lt",       ALU_LT,    32'hFFFF_FFFF,  32'd1,   32'd0,     1'b0, 32'd1);
        base("ltu",      ALU_LTU,   32'hFFFF_FFFF,  32'd1,   32'd0,     1'b0, 32'd0);
        base("xor",      ALU_XOR,   32'hF0F0_0000,  32'h0FF0_0000, 32'd0, 1'b0, 32'hFF00_0000);
        base("addpc_j",  ALU_ADDPC, 32'd0,          32'h20,  32'h100,   1'b1, 32'h104);
        base("addpc_b",  ALU_ADDPC, 32'd0,          32'h20,  32'h100,   1'b0, 32'h120);
        base("unknown",  5'd15,     32'd3,          32'd4,   32'd0,     1'b0, 32'd0);

        // M ops
        run_md("mul",     ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, -1);
        run_md("mulh",    ALU_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, -1);
        run_md("mulhu",   ALU_MULHU,  32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 33, -1);
        run_md("mulhsu",  ALU_MULHSU, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 33, -1);
        run_md("div",     ALU_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33, -1);
        run_md("rem",     ALU_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33, -1);
        run_md("divu",    ALU_DIVU,   32'd100,        32'd7,         32'd14,        33, -1);
        run_md("remu",    ALU_REMU,   32'd100,        32'd7,         32'd2,         33, -1);
        run_md("divu_z",  ALU_DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF, 1,  -1);
        run_md("remu_z",  ALU_REMU,   32'h1234,       32'd0,         32'h1234,      1,  -1);
        run_md("div_z",   ALU_DIV,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFFF, 1,  -1);
        run_md("rem_z",   ALU_REM,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC, 1,  -1);
        run_md("div_ovf", ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  -1);
        run_md("rem_ovf", ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  -1);
        run_md("mul_fwd", ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 4);

        // Flush mid-CALC, then a normal ADD
        set_rr(ALU_MUL, 32'd9, 32'd9);
        repeat (11) @(negedge clk);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", {31'd0, ex_stall}, 32'd0);
        step();
        flush = 1'b0;
        set_rr(ALU_ADD, 32'd2, 32'd3);
        @(negedge clk);
        chk("post_flush_busy", {31'd0, md_busy}, 32'd0);
        chk("post_flush_add", alu_result, 32'd5);
        step();
        ex_valid = 1'b0;

        // Reset mid-CALC
        set_rr(ALU_MUL, 32'd9, 32'd9);
        repeat (6) @(negedge clk);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, ex_stall}, 32'd0);
        step();
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_mid_result", alu_result, 32'd0);
        chk("rst_mid_stall2", {31'd0, ex_stall}, 32'd0);
        step();
        rst_n = 1'b1;
        ex_valid = 1'b0;
        step();
        base("post_rst_add", ALU_ADD, 32'd40, 32'd2, 32'd0, 1'b0, 32'd42);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
